// File: rtl/pool_flatten_stream.sv
// ---------------------------------------------------------------------------
// pool_flatten_stream
//
// Streaming POOL_SIZE x POOL_SIZE non-overlapping max/average pooling with
// optional ReLU. Pixels arrive one per handshake in channel-major raster order.
// Pooled values leave as a flattened stream ordered channel, row, column.
//
// Ports
//   clk        rising-edge clock
//   rst_pool   asynchronous active-low reset
//   start      one-cycle frame start pulse (honoured only when idle)
//   mode       0 = max, 1 = average (sampled at start)
//   relu_en    clamp negative results to 0 (sampled at start)
//   in_data    signed input pixel
//   in_valid   input pixel valid
//   in_ready   input pixel accepted when in_valid && in_ready
//   out_data   signed pooled value
//   out_index  flattened output position
//   out_valid  output valid
//   out_ready  output accepted when out_valid && out_ready
//   out_last   marks index FLAT_LEN-1
//   busy       frame in progress
//   done       one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
module pool_flatten_stream #(
   parameter  int IN_WIDTH     = 10,
   parameter  int IN_HEIGHT    = 10,
   parameter  int NUM_CHANNELS = 2,
   parameter  int POOL_SIZE    = 2,
   parameter  int DATA_WIDTH   = 8,
   localparam int OUT_W        = IN_WIDTH / POOL_SIZE,
   localparam int OUT_H        = IN_HEIGHT / POOL_SIZE,
   localparam int FLAT_LEN     = NUM_CHANNELS * OUT_H * OUT_W,
   localparam int IDX_W        = (FLAT_LEN > 1) ? $clog2(FLAT_LEN) : 1
) (
   input  logic                         clk,
   input  logic                         rst_pool,
   input  logic                         start,
   input  logic                         mode,
   input  logic                         relu_en,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic [IDX_W-1:0]             out_index,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         busy,
   output logic                         done
);

   localparam int LOG_P  = $clog2(POOL_SIZE);
   // Sum of P*P pixels needs 2*log2(P) guard bits.
   localparam int ACC_W  = DATA_WIDTH + 2 * LOG_P;
   // One spare bit so OUT_W*P / OUT_H*P always fit for range compares.
   localparam int COL_W  = $clog2(IN_WIDTH + 1);
   localparam int ROW_W  = $clog2(IN_HEIGHT + 1);
   localparam int CH_W   = $clog2(NUM_CHANNELS + 1);
   localparam int BUF_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                  state_r;
   logic                    mode_r;
   logic                    relu_r;
   logic                    busy_r;
   logic                    done_r;

   logic [COL_W-1:0]        col_r;
   logic [ROW_W-1:0]        row_r;
   logic [CH_W-1:0]         ch_r;
   // Running flattened-index bases: ch*OUT_H*OUT_W and (row/P)*OUT_W.
   logic [IDX_W-1:0]        ch_base_r;
   logic [IDX_W-1:0]        prow_base_r;

   logic signed [ACC_W-1:0] part_r [OUT_W];

   logic signed [DATA_WIDTH-1:0] out_data_r;
   logic [IDX_W-1:0]        out_index_r;
   logic                    out_valid_r;
   logic                    out_last_r;

   logic                    in_ready_s;
   logic                    accept_s;
   logic                    col_end_s;
   logic                    row_end_s;
   logic                    ch_end_s;
   logic                    frame_end_s;
   logic                    in_range_s;
   logic [LOG_P-1:0]        col_ph_s;
   logic [LOG_P-1:0]        row_ph_s;
   logic                    win_first_s;
   logic                    win_last_s;
   logic [BUF_AW-1:0]       bucket_s;
   logic signed [ACC_W-1:0] pix_ext_s;
   logic signed [ACC_W-1:0] entry_s;
   logic signed [ACC_W-1:0] merged_s;
   logic signed [DATA_WIDTH-1:0] pooled_s;
   logic signed [DATA_WIDTH-1:0] result_s;
   logic [IDX_W-1:0]        idx_s;

   assign in_ready_s  = (state_r == ST_RUN) && (!out_valid_r || out_ready);
   assign accept_s    = in_valid && in_ready_s;

   assign col_end_s   = (col_r == COL_W'(IN_WIDTH - 1));
   assign row_end_s   = (row_r == ROW_W'(IN_HEIGHT - 1));
   assign ch_end_s    = (ch_r == CH_W'(NUM_CHANNELS - 1));
   assign frame_end_s = col_end_s && row_end_s && ch_end_s;

   // Trailing columns/rows that do not fill a full window are dropped.
   assign in_range_s  = (col_r < COL_W'(OUT_W * POOL_SIZE)) &&
                        (row_r < ROW_W'(OUT_H * POOL_SIZE));

   // POOL_SIZE is a power of two, so the window phase is the low bits.
   assign col_ph_s    = col_r[LOG_P-1:0];
   assign row_ph_s    = row_r[LOG_P-1:0];
   assign win_first_s = (col_ph_s == {LOG_P{1'b0}}) && (row_ph_s == {LOG_P{1'b0}});
   assign win_last_s  = (col_ph_s == {LOG_P{1'b1}}) && (row_ph_s == {LOG_P{1'b1}});

   assign bucket_s    = BUF_AW'(col_r >> LOG_P);
   assign pix_ext_s   = {{(2 * LOG_P){in_data[DATA_WIDTH-1]}}, in_data};
   assign entry_s     = part_r[bucket_s];
   assign idx_s       = ch_base_r + prow_base_r + IDX_W'(bucket_s);

   // Fold the incoming pixel into its column bucket (load / max / sum).
   always_comb begin
      merged_s = pix_ext_s;
      if (win_first_s) begin
         merged_s = pix_ext_s;
      end else if (mode_r) begin
         merged_s = entry_s + pix_ext_s;
      end else if (entry_s > pix_ext_s) begin
         merged_s = entry_s;
      end else begin
         merged_s = pix_ext_s;
      end
   end

   // Final pooled value: slicing above the guard bits is an arithmetic
   // shift right (floor) whose result always fits DATA_WIDTH.
   always_comb begin
      pooled_s = merged_s[DATA_WIDTH-1:0];
      if (mode_r) begin
         pooled_s = merged_s[2 * LOG_P +: DATA_WIDTH];
      end else begin
         pooled_s = merged_s[DATA_WIDTH-1:0];
      end
   end

   assign result_s = (relu_r && pooled_s[DATA_WIDTH-1]) ? {DATA_WIDTH{1'b0}} : pooled_s;

   // Frame control FSM with registered busy/done and latched frame options.
   always_ff @(posedge clk or negedge rst_pool) begin
      if (!rst_pool) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         mode_r  <= 1'b0;
         relu_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r <= ST_RUN;
                  busy_r  <= 1'b1;
                  mode_r  <= mode;
                  relu_r  <= relu_en;
               end
            end
            ST_RUN: begin
               if (accept_s && frame_end_s) begin
                  state_r <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               // Leave once nothing is pending or the pending output drains.
               if (!out_valid_r || out_ready) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // Pixel position counters and flattened-index bases.
   always_ff @(posedge clk or negedge rst_pool) begin
      if (!rst_pool) begin
         col_r       <= {COL_W{1'b0}};
         row_r       <= {ROW_W{1'b0}};
         ch_r        <= {CH_W{1'b0}};
         ch_base_r   <= {IDX_W{1'b0}};
         prow_base_r <= {IDX_W{1'b0}};
      end else if ((state_r == ST_IDLE) && start) begin
         col_r       <= {COL_W{1'b0}};
         row_r       <= {ROW_W{1'b0}};
         ch_r        <= {CH_W{1'b0}};
         ch_base_r   <= {IDX_W{1'b0}};
         prow_base_r <= {IDX_W{1'b0}};
      end else if (accept_s) begin
         if (col_end_s) begin
            col_r <= {COL_W{1'b0}};
            if (row_end_s) begin
               row_r       <= {ROW_W{1'b0}};
               prow_base_r <= {IDX_W{1'b0}};
               if (ch_end_s) begin
                  ch_r      <= {CH_W{1'b0}};
                  ch_base_r <= {IDX_W{1'b0}};
               end else begin
                  ch_r      <= ch_r + CH_W'(1);
                  ch_base_r <= ch_base_r + IDX_W'(OUT_H * OUT_W);
               end
            end else begin
               row_r <= row_r + ROW_W'(1);
               if (row_ph_s == {LOG_P{1'b1}}) begin
                  prow_base_r <= prow_base_r + IDX_W'(OUT_W);
               end
            end
         end else begin
            col_r <= col_r + COL_W'(1);
         end
      end
   end

   // Partial window buffer; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (accept_s && in_range_s) begin
         part_r[bucket_s] <= merged_s;
      end
   end

   // Single output register: loads on a window's last pixel, clears on drain.
   always_ff @(posedge clk or negedge rst_pool) begin
      if (!rst_pool) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_WIDTH{1'b0}};
         out_index_r <= {IDX_W{1'b0}};
         out_last_r  <= 1'b0;
      end else if (accept_s && in_range_s && win_last_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= result_s;
         out_index_r <= idx_s;
         out_last_r  <= (idx_s == IDX_W'(FLAT_LEN - 1));
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_r;
   assign out_index = out_index_r;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_pool_flatten_stream.sv
module tb_pool_flatten_stream;

   localparam int P = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_pool;

   // DUT A: 10x10x2 defaults
   logic start_a, mode_a, relu_a, in_valid_a, out_ready_a;
   logic signed [7:0] in_data_a, out_data_a;
   logic in_ready_a, out_valid_a, out_last_a, busy_a, done_a;
   logic [5:0] out_index_a;

   // DUT B: 5x5x1 (odd edge dropped)
   logic start_b, mode_b, relu_b, in_valid_b, out_ready_b;
   logic signed [7:0] in_data_b, out_data_b;
   logic in_ready_b, out_valid_b, out_last_b, busy_b, done_b;
   logic [1:0] out_index_b;

   pool_flatten_stream dut_a (
      .clk(clk), .rst_pool(rst_pool), .start(start_a), .mode(mode_a), .relu_en(relu_a),
      .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .out_data(out_data_a), .out_index(out_index_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .out_last(out_last_a), .busy(busy_a), .done(done_a));

   pool_flatten_stream #(.IN_WIDTH(5), .IN_HEIGHT(5), .NUM_CHANNELS(1)) dut_b (
      .clk(clk), .rst_pool(rst_pool), .start(start_b), .mode(mode_b), .relu_en(relu_b),
      .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .out_data(out_data_b), .out_index(out_index_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_last(out_last_b), .busy(busy_b), .done(done_b));

   typedef struct {int idx; int data; int last;} exp_t;
   exp_t exp_a[$];
   exp_t exp_b[$];
   exp_t e_a, e_b;

   int img_a[200];
   int img_b[25];
   int got_a[50];
   int n_vec = 0;
   int n_err = 0;
   int n_done[2];
   int n_out[2];
   int ready_mode[2];
   bit stall_done;
   bit held_a;
   int hd_a, hi_a, hl_a;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   // Reference model: pool each output window straight from the image array.
   task automatic build_expected(input int sel, input int md, input int rl);
      int w, h, nc, ow, oh, v, acc;
      exp_t e;
      w = sel ? 5 : 10; h = w; nc = sel ? 1 : 2;
      ow = w / P; oh = h / P;
      for (int ch = 0; ch < nc; ch++)
         for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++) begin
               acc = md ? 0 : -100000;
               for (int dy = 0; dy < P; dy++)
                  for (int dx = 0; dx < P; dx++) begin
                     v = sel ? img_b[ch*h*w + (oy*P+dy)*w + ox*P+dx]
                             : img_a[ch*h*w + (oy*P+dy)*w + ox*P+dx];
                     if (md) acc += v;
                     else if (v > acc) acc = v;
                  end
               if (md) acc = floor_div(acc, P*P);
               if (rl && acc < 0) acc = 0;
               e.idx = ch*oh*ow + oy*ow + ox;
               e.data = acc;
               e.last = (e.idx == nc*oh*ow - 1) ? 1 : 0;
               if (sel) exp_b.push_back(e); else exp_a.push_back(e);
            end
   endtask

   task automatic ramp_a(input int offset);
      for (int ch = 0; ch < 2; ch++)
         for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
               img_a[ch*100 + r*10 + c] = r*10 + c - 50*ch - offset;
   endtask

   task automatic random_a();
      for (int i = 0; i < 200; i++) img_a[i] = int'($urandom_range(0, 255)) - 128;
   endtask

   task automatic random_b();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            img_b[r*5 + c] = (r == 4 || c == 4) ? 127 : int'($urandom_range(0, 200)) - 128;
   endtask

   task automatic drive_ctl(input int sel, input bit st, input int md, input int rl);
      if (sel) begin start_b = st; mode_b = md[0]; relu_b = rl[0]; end
      else     begin start_a = st; mode_a = md[0]; relu_a = rl[0]; end
   endtask

   task automatic drive_pix(input int sel, input bit v, input int d);
      if (sel) begin in_valid_b = v; in_data_b = 8'(d); end
      else     begin in_valid_a = v; in_data_a = 8'(d); end
   endtask

   task automatic run_frame(input int sel, input int md, input int rl,
                            input int rand_valid, input int limit, input bit wait_done);
      int npix, p, guard, done0, d;
      bit v, acc;
      npix = sel ? 25 : 200;
      if (limit >= 0 && limit < npix) npix = limit;
      build_expected(sel, md, rl);
      done0 = n_done[sel];
      drive_ctl(sel, 1'b1, md, rl);
      @(posedge clk); #1;
      drive_ctl(sel, 1'b0, md, rl);
      p = 0; guard = 0;
      while (p < npix && guard < 5000) begin
         v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
         d = sel ? img_b[p] : img_a[p];
         drive_pix(sel, v, d);
         @(negedge clk);
         acc = v && (sel ? in_ready_b : in_ready_a);
         @(posedge clk); #1;
         if (acc) p++;
         guard++;
      end
      drive_pix(sel, 1'b0, 0);
      if (p < npix) check("pixel_timeout", p, npix);
      if (wait_done) begin
         guard = 0;
         while (n_done[sel] == done0 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
         end
         repeat (3) @(posedge clk);
         #1;
         check("done_once", n_done[sel] - done0, 1);
         check("drained", sel ? exp_b.size() : exp_a.size(), 0);
         check("busy_after", sel ? busy_b : busy_a, 0);
      end
   endtask

   task automatic check_reset_a();
      check("rst_in_ready", in_ready_a, 0);
      check("rst_out_valid", out_valid_a, 0);
      check("rst_out_data", out_data_a, 0);
      check("rst_out_index", out_index_a, 0);
      check("rst_out_last", out_last_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
   endtask

   // out_ready drivers: 0 = always ready, 1 = random, 2 = one 5-cycle stall
   initial begin
      out_ready_a = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode[0])
            1: out_ready_a = 1'($urandom_range(0, 1));
            2: begin
               if (out_valid_a && !stall_done) begin
                  out_ready_a = 1'b0;
                  repeat (5) @(posedge clk);
                  #1;
                  stall_done = 1'b1;
               end
               out_ready_a = 1'b1;
            end
            default: out_ready_a = 1'b1;
         endcase
      end
   end

   initial begin
      out_ready_b = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready_b = (ready_mode[1] == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor A: scoreboard, hold-while-stalled, done/busy relation
   always @(negedge clk) begin
      if (!rst_pool) begin
         held_a = 1'b0;
      end else begin
         if (held_a) begin
            check("hold_valid", out_valid_a, 1);
            check("hold_data", out_data_a, hd_a);
            check("hold_index", out_index_a, hi_a);
            check("hold_last", out_last_a, hl_a);
         end
         if (out_valid_a && !out_ready_a) begin
            check("stall_in_ready", in_ready_a, 0);
            held_a = 1'b1; hd_a = out_data_a; hi_a = out_index_a; hl_a = out_last_a;
         end else begin
            held_a = 1'b0;
         end
         if (out_valid_a && out_ready_a) begin
            n_out[0]++;
            if (exp_a.size() == 0) begin
               check("extra_out_a", int'(out_index_a), -1);
            end else begin
               e_a = exp_a.pop_front();
               check("data_a", out_data_a, e_a.data);
               check("index_a", out_index_a, e_a.idx);
               check("last_a", out_last_a, e_a.last);
            end
            if (out_index_a < 6'd50) got_a[out_index_a] = out_data_a;
         end
         if (done_a) begin
            n_done[0]++;
            check("done_busy_a", busy_a, 0);
         end
      end
   end

   // Monitor B: scoreboard and done
   always @(negedge clk) begin
      if (rst_pool) begin
         if (out_valid_b && !out_ready_b) check("stall_in_ready_b", in_ready_b, 0);
         if (out_valid_b && out_ready_b) begin
            n_out[1]++;
            if (exp_b.size() == 0) begin
               check("extra_out_b", int'(out_index_b), -1);
            end else begin
               e_b = exp_b.pop_front();
               check("data_b", out_data_b, e_b.data);
               check("index_b", out_index_b, e_b.idx);
               check("last_b", out_last_b, e_b.last);
            end
         end
         if (done_b) begin
            n_done[1]++;
            check("done_busy_b", busy_b, 0);
         end
      end
   end

   initial begin
      int o0, md, rl;
      rst_pool = 1'b0;
      drive_ctl(0, 1'b0, 0, 0); drive_ctl(1, 1'b0, 0, 0);
      drive_pix(0, 1'b0, 0); drive_pix(1, 1'b0, 0);
      ready_mode[0] = 0; ready_mode[1] = 0; stall_done = 1'b0;
      n_done[0] = 0; n_done[1] = 0; n_out[0] = 0; n_out[1] = 0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_a();
      rst_pool = 1'b1;
      @(posedge clk); #1;

      // max pooling, pixel = r*10+c-50-50*ch
      ramp_a(50);
      o0 = n_out[0];
      run_frame(0, 0, 0, 0, -1, 1'b1);
      check("t1_count", n_out[0] - o0, 50);
      check("t1_idx0", got_a[0], -39);
      check("t1_idx24", got_a[24], 49);
      check("t1_idx25", got_a[25], -89);
      check("t1_idx49", got_a[49], -1);

      // average pooling, pixel = r*10+c-50*ch
      ramp_a(0);
      run_frame(0, 1, 0, 0, -1, 1'b1);
      check("avg_idx0", got_a[0], 5);
      check("avg_idx25", got_a[25], -45);
      run_frame(0, 1, 1, 0, -1, 1'b1);
      check("relu_idx0", got_a[0], 5);
      check("relu_idx25", got_a[25], 0);

      // floor of negative mean, and saturated sum with no overflow
      random_a();
      img_a[0] = -1; img_a[1] = -2; img_a[10] = -2; img_a[11] = -2;
      img_a[2] = 127; img_a[3] = 127; img_a[12] = 127; img_a[13] = 127;
      run_frame(0, 1, 0, 1, -1, 1'b1);
      check("win_neg", got_a[0], -2);
      check("win_max", got_a[1], 127);

      // backpressure: 5-cycle stall at the first output
      ramp_a(50);
      stall_done = 1'b0;
      ready_mode[0] = 2;
      o0 = n_out[0];
      run_frame(0, 0, 0, 0, -1, 1'b1);
      ready_mode[0] = 0;
      check("stall_seen", stall_done, 1);
      check("stall_count", n_out[0] - o0, 50);
      check("stall_idx0", got_a[0], -39);
      check("stall_idx49", got_a[49], -1);

      // 5x5 single channel: row 4 / column 4 hold 127 but must be dropped
      for (int k = 0; k < 2; k++) begin
         random_b();
         o0 = n_out[1];
         run_frame(1, k, 0, 0, -1, 1'b1);
         check("b_count", n_out[1] - o0, 4);
      end

      // randomized frames with random valid / ready
      ready_mode[0] = 1; ready_mode[1] = 1;
      for (int k = 0; k < 4; k++) begin
         md = int'($urandom_range(0, 1)); rl = int'($urandom_range(0, 1));
         random_a();
         run_frame(0, md, rl, 1, -1, 1'b1);
         random_b();
         run_frame(1, md, rl, 1, -1, 1'b1);
      end
      ready_mode[0] = 0; ready_mode[1] = 0;

      // reset mid-frame after 30 pixels, then a clean frame
      ramp_a(50);
      run_frame(0, 0, 0, 0, 30, 1'b0);
      rst_pool = 1'b0;
      #1;
      check_reset_a();
      exp_a.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_pool = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 50; i++) got_a[i] = 999;
      o0 = n_out[0];
      run_frame(0, 0, 0, 0, -1, 1'b1);
      check("post_rst_count", n_out[0] - o0, 50);
      check("post_rst_idx0", got_a[0], -39);
      check("post_rst_idx49", got_a[49], -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
